// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
//   Single-entry dispatch controller for a 1-to-2 demultiplexed datapath.
//   It takes one word from a valid/ready producer into a holding register.
//   It then delivers that word to exactly one of two consumers (a or b).
//   It also drives the demux select line to match the held word's destination.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   producer handshake
//   in_data, in_dest    word and its destination (0 = a, 1 = b)
//   a_valid/a_ready     consumer a handshake, a_data word to a
//   b_valid/b_ready     consumer b handshake, b_data word to b
//   select              demux select, equals destination of held word
//   busy                holding register occupied
//
// Build option
//   DEMUX_DISPATCH_RR_EN  ignores in_dest. The destination alternates a, b, a, b ...
//                         and is tracked by an internal round-robin pointer.
//
// State table
//   EMPTY | no word held; in_ready = 1
//   FULL  | word held in hold_data/hold_dest; offered on the selected channel
module demux_dispatch_ctrl #(
  parameter int bus_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bus_size-1:0] in_data,
  input  logic                in_dest,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [bus_size-1:0] a_data,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [bus_size-1:0] b_data,
  output logic                select,
  output logic                busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [bus_size-1:0] hold_data;
  logic                hold_dest;
  logic                in_xfer;
  logic                sel_ready;
  logic                cap_dest;

`ifdef DEMUX_DISPATCH_RR_EN
  logic rr_ptr;
  logic unused_in_dest;
  assign unused_in_dest = in_dest;
  assign cap_dest = rr_ptr;
`else
  assign cap_dest = in_dest;
`endif

  // Ready of the channel the held word is addressed to; the other ready is ignored.
  assign sel_ready = hold_dest ? b_ready : a_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_dest <= 1'b0;
    end else begin
      state <= state_nxt;
      // In FULL an input transfer only happens together with an output transfer.
      // That case is the one-word-per-cycle reload.
      if (in_xfer) begin
        hold_data <= in_data;
        hold_dest <= cap_dest;
      end
    end
  end

`ifdef DEMUX_DISPATCH_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= 1'b0;
    else if (in_xfer) rr_ptr <= ~rr_ptr;
  end
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    select    = 1'b0;
    busy      = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = FULL;
      end
      FULL: begin
        busy     = 1'b1;
        select   = hold_dest;
        in_ready = sel_ready;
        if (hold_dest) begin
          b_valid = 1'b1;
          b_data  = hold_data;
        end else begin
          a_valid = 1'b1;
          a_data  = hold_data;
        end
        if (sel_ready && !in_valid) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    // The producer must never see ready while reset is held.
    if (rst) in_ready = 1'b0;
  end

  assign in_xfer = in_valid & in_ready;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_dest;
  logic [31:0] in_data;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [31:0] a_data, b_data;
  logic        select, busy;

  int tests = 0;
  int fails = 0;

`ifdef DEMUX_DISPATCH_RR_EN
  localparam bit rr_mode = 1'b1;
`else
  localparam bit rr_mode = 1'b0;
`endif

  demux_dispatch_ctrl #(.bus_size(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .select(select), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234; in_dest = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++;
    if ({a_valid, b_valid, busy, select} !== 4'b0) begin
      fails++; $display("FAIL reset_outputs got av=%b bv=%b busy=%b sel=%b want 0", a_valid, b_valid, busy, select);
    end
    tests++;
    if (a_data !== 32'h0 || b_data !== 32'h0) begin
      fails++; $display("FAIL reset_data got a=%h b=%h want 0", a_data, b_data);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset got in_ready=%b busy=%b want 1,0", in_ready, busy);
    end
  endtask

  task automatic test_single_b();
    logic exp_d;
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000000B; in_dest = 1'b1;
    exp_d = rr_mode ? 1'b0 : 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (b_valid !== exp_d || a_valid !== !exp_d || select !== exp_d || busy !== 1'b1) begin
      fails++; $display("FAIL single_valids got av=%b bv=%b sel=%b busy=%b want dest=%b", a_valid, b_valid, select, busy, exp_d);
    end
    tests++;
    if ((exp_d ? b_data : a_data) !== 32'hB || (exp_d ? a_data : b_data) !== 32'h0) begin
      fails++; $display("FAIL single_data got a=%h b=%h want B on dest %b", a_data, b_data, exp_d);
    end
    @(posedge clk); #1;
    tests++;
    if ({a_valid, b_valid, busy} !== 3'b0 || a_data !== 32'h0 || b_data !== 32'h0) begin
      fails++; $display("FAIL single_drain got av=%b bv=%b busy=%b a=%h b=%h want empty", a_valid, b_valid, busy, a_data, b_data);
    end
  endtask

  task automatic test_backpressure();
    logic exp_d2;
    do_reset();
    a_ready = 1'b0; b_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_dest = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (a_valid !== 1'b1 || a_data !== 32'hA5A5A5A5 || in_ready !== 1'b0 || b_valid !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got av=%b a=%h in_ready=%b bv=%b want 1,a5a5a5a5,0,0", i, a_valid, a_data, in_ready, b_valid);
      end
      @(posedge clk); #1;
    end
    a_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_passthrough got in_ready=%b want 1", in_ready); end
    exp_d2 = rr_mode ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || select !== exp_d2 || (exp_d2 ? b_data : a_data) !== 32'h1 ||
        (exp_d2 ? b_valid : a_valid) !== 1'b1) begin
      fails++; $display("FAIL bp_reload got busy=%b sel=%b a=%h b=%h want word 1 on dest %b", busy, select, a_data, b_data, exp_d2);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL bp_drain got busy=%b want 0", busy); end
  endtask

  task automatic run_four(input logic [3:0] dests, input string tag);
    logic exp_d;
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'(k + 1); in_dest = dests[k];
      exp_d = rr_mode ? 1'(k % 2) : dests[k];
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready[%0d] got %b want 1", tag, k, in_ready); end
      @(posedge clk); #1;
      tests++;
      if (select !== exp_d || (exp_d ? b_valid : a_valid) !== 1'b1 || (exp_d ? a_valid : b_valid) !== 1'b0 ||
          (exp_d ? b_data : a_data) !== 32'(k + 1) || (exp_d ? a_data : b_data) !== 32'h0) begin
        fails++; $display("FAIL %s_word[%0d] got sel=%b av=%b bv=%b a=%h b=%h want %0d on dest %b",
                          tag, k, select, a_valid, b_valid, a_data, b_data, k + 1, exp_d);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s_drain got busy=%b want 0", tag, busy); end
  endtask

  task automatic test_streaming();
    run_four(4'b1010, "stream");
  endtask

  task automatic test_dest_pattern();
    run_four(4'b1111, "dest_all_b");
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_dest = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (a_valid !== 1'b1 || a_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rstmid_full got av=%b a=%h want 1,deadbeef", a_valid, a_data);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (a_valid !== 1'b0 || busy !== 1'b0 || a_data !== 32'h0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_async got av=%b busy=%b a=%h in_ready=%b want 0,0,0,0", a_valid, busy, a_data, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL rstmid_gone[%0d] got av=%b bv=%b busy=%b want 0", i, a_valid, b_valid, busy);
      end
    end
  endtask

  // Reference: a one-word store holding {dest, data}, filled and drained by handshakes.
  task automatic test_random();
    logic [32:0] q[$];
    int          accepted = 0;
    logic        e_in_ready, e_av, e_bv, e_busy, in_fire, out_fire, d;
    logic [31:0] e_ad, e_bd;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      in_dest  = 1'($urandom);
      a_ready  = 1'($urandom_range(0, 9) < 7);
      b_ready  = 1'($urandom_range(0, 9) < 6);
      #1;
      e_av = 1'b0; e_bv = 1'b0; e_ad = '0; e_bd = '0; e_busy = 1'b0; e_in_ready = 1'b1;
      out_fire = 1'b0;
      if (q.size() != 0) begin
        e_busy = 1'b1;
        if (q[0][32]) begin e_bv = 1'b1; e_bd = q[0][31:0]; e_in_ready = b_ready; end
        else          begin e_av = 1'b1; e_ad = q[0][31:0]; e_in_ready = a_ready; end
        out_fire = e_in_ready;
      end
      tests++;
      if ({in_ready, a_valid, b_valid, busy, a_data, b_data} !== {e_in_ready, e_av, e_bv, e_busy, e_ad, e_bd} ||
          (e_busy && select !== q[0][32])) begin
        fails++; $display("FAIL random[%0d] got rdy=%b av=%b bv=%b busy=%b sel=%b a=%h b=%h want rdy=%b av=%b bv=%b busy=%b a=%h b=%h",
                          cyc, in_ready, a_valid, b_valid, busy, select, a_data, b_data, e_in_ready, e_av, e_bv, e_busy, e_ad, e_bd);
      end
      in_fire = in_valid && e_in_ready;
      d = rr_mode ? 1'(accepted % 2) : in_dest;
      @(posedge clk); #1;
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin q.push_back({d, in_data}); accepted++; end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_b();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_dest_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
